matmul_ab: RTL and testbench

- Consumer of the matrix-A and matrix-B generator stages.
- Waits until both generators report their BRAM as written (wrA_done, wrB_done).
- Reads A (N x P) and B (P x M) through their synchronous read ports and computes C = A x B with unsigned multiply-accumulate.
- Streams each C element, row-major, to a result BRAM write port, then raises a sticky mm_done.

---
 rtl/matmul_ab.sv | 191 +++++++++++++++++++
 tb/tb_matmul_ab.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_ab.sv
// matmul_ab: waits for the A/B generators, then computes C = A x B from two BRAM read ports
// and streams C row-major to a result write port. Define MATMUL_SAT_EN for saturating MAC and the ovf flag.
module matmul_ab #(
    parameter int N      = 2,
    parameter int P      = 4,
    parameter int M      = 3,
    parameter int DW     = 32,
    parameter int AW     = 8,
    parameter int A_BASE = 0,
    parameter int B_BASE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wrA_done,
    input  logic          wrB_done,
    output logic [AW-1:0] addrbA,
    input  logic [DW-1:0] doutbA,
    output logic [AW-1:0] addrbB,
    input  logic [DW-1:0] doutbB,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_din,
`ifdef MATMUL_SAT_EN
    output logic          ovf,
`endif
    output logic          busy,
    output logic          mm_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (P > 1) ? $clog2(P) : 1;
`ifdef MATMUL_SAT_EN
    localparam int ACCW = DW + 1;
`else
    localparam int ACCW = DW;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]   i;
    logic [JW-1:0]   j;
    logic [KW-1:0]   k;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_next;
    logic            pipe;
    logic [AW-1:0]   addr_a_hold;
    logic [AW-1:0]   addr_b_hold;
    logic [AW-1:0]   addr_a_now;
    logic [AW-1:0]   addr_b_now;
    logic [AW-1:0]   c_addr_now;
    logic            i_last;
    logic            j_last;
    logic            k_last;

    assign i_last = (i == IW'(N - 1));
    assign j_last = (j == JW'(M - 1));
    assign k_last = (k == KW'(P - 1));

    assign addr_a_now = AW'(A_BASE + P * int'(i) + int'(k));
    assign addr_b_now = AW'(B_BASE + M * int'(k) + int'(j));
    assign c_addr_now = AW'(M * int'(i) + int'(j));

    // Multiply-accumulate of the BRAM words that arrive one cycle behind their addresses.
`ifdef MATMUL_SAT_EN
    localparam logic [ACCW-1:0] ACC_MAX = {1'b0, {DW{1'b1}}};

    logic [2*DW-1:0] product;
    logic [ACCW-1:0] sum;
    logic            overflow;

    always_comb begin
        product  = (2*DW)'(doutbA) * (2*DW)'(doutbB);
        sum      = acc + ACCW'(product[DW-1:0]);
        overflow = (product[2*DW-1:DW] != '0) || sum[DW];
        acc_next = overflow ? ACC_MAX : sum;
    end
`else
    always_comb begin
        acc_next = acc + doutbA * doutbB;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wrA_done && wrB_done) state_next = FETCH;
            FETCH:   if (k_last) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   state_next = (i_last && j_last) ? DONE : FETCH;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Loop counters, accumulator and the held read addresses; WRITE rolls over to the next element.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            acc         <= '0;
            pipe        <= 1'b0;
            addr_a_hold <= '0;
            addr_b_hold <= '0;
        end else begin
            pipe <= (state == FETCH);
            if (pipe) begin
                acc <= acc_next;
            end
            if (state == FETCH) begin
                addr_a_hold <= addr_a_now;
                addr_b_hold <= addr_b_now;
                if (!k_last) begin
                    k <= k + KW'(1);
                end
            end
            if (state == WRITE) begin
                acc <= '0;
                k   <= '0;
                if (j_last) begin
                    j <= '0;
                    if (!i_last) begin
                        i <= i + IW'(1);
                    end
                end else begin
                    j <= j + JW'(1);
                end
            end
        end
    end

`ifdef MATMUL_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (pipe && overflow) begin
            ovf <= 1'b1;
        end
    end
`endif

    always_comb begin
        busy    = 1'b0;
        mm_done = 1'b0;
        c_we    = 1'b0;
        c_addr  = '0;
        c_din   = '0;
        addrbA  = addr_a_hold;
        addrbB  = addr_b_hold;
        case (state)
            FETCH: begin
                busy   = 1'b1;
                addrbA = addr_a_now;
                addrbB = addr_b_now;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            WRITE: begin
                busy   = 1'b1;
                c_we   = 1'b1;
                c_addr = c_addr_now;
                c_din  = acc[DW-1:0];
            end
            DONE: begin
                mm_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_ab.sv
// tb_matmul_ab: directed scenarios for matmul_ab with BRAM models and a queue scoreboard of
// expected C writes; follows MATMUL_SAT_EN for the ovf port and saturating expectations.
module tb_matmul_ab;

    localparam int N      = 2;
    localparam int P      = 4;
    localparam int M      = 3;
    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int A_BASE = 0;
    localparam int B_BASE = 0;
    localparam int ELEM_CYCLES = P + 2;
    localparam int DONE_EDGE   = N * M * ELEM_CYCLES + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          wrA_done;
    logic          wrB_done;
    logic [AW-1:0] addrbA;
    logic [DW-1:0] doutbA;
    logic [AW-1:0] addrbB;
    logic [DW-1:0] doutbB;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_din;
`ifdef MATMUL_SAT_EN
    logic          ovf;
`endif
    logic          busy;
    logic          mm_done;

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];

    exp_t sb[$];
    int   checks;
    int   errors;
    int   edge_count;
    int   we_count;
    int   last_we_edge;

    matmul_ab #(
        .N(N), .P(P), .M(M), .DW(DW), .AW(AW), .A_BASE(A_BASE), .B_BASE(B_BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wrA_done(wrA_done),
        .wrB_done(wrB_done),
        .addrbA(addrbA),
        .doutbA(doutbA),
        .addrbB(addrbB),
        .doutbB(doutbB),
        .c_we(c_we),
        .c_addr(c_addr),
        .c_din(c_din),
`ifdef MATMUL_SAT_EN
        .ovf(ovf),
`endif
        .busy(busy),
        .mm_done(mm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM models: data follows the address by one clock.
    always @(posedge clk) begin
        doutbA <= mem_a[addrbA];
        doutbB <= mem_b[addrbB];
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: C = A x B with modulo or saturating arithmetic, pushed row-major.
    task automatic push_expected();
        logic [DW-1:0]   acc;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] prod;
        logic [2*DW:0]   wide;
        exp_t            e;
        for (int ii = 0; ii < N; ii++) begin
            for (int jj = 0; jj < M; jj++) begin
                acc = '0;
                for (int kk = 0; kk < P; kk++) begin
                    a    = mem_a[(A_BASE + ii*P + kk) % (1 << AW)];
                    b    = mem_b[(B_BASE + kk*M + jj) % (1 << AW)];
                    prod = (2*DW)'(a) * (2*DW)'(b);
`ifdef MATMUL_SAT_EN
                    wide = (2*DW+1)'(acc) + (2*DW+1)'(prod);
                    acc  = (wide > (2*DW+1)'({DW{1'b1}})) ? {DW{1'b1}} : wide[DW-1:0];
`else
                    wide = '0;
                    acc  = acc + prod[DW-1:0];
`endif
                end
                e.addr = AW'(ii*M + jj);
                e.data = acc;
                sb.push_back(e);
            end
        end
    endtask

    // One clock: sample #1 after the edge and score any result write.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        edge_count++;
        if (c_we) begin
            we_count++;
            if (sb.size() == 0) begin
                check_output("unexpected_we", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check_output("c_addr", 64'(c_addr), 64'(e.addr));
                check_output("c_din", 64'(c_din), 64'(e.data));
            end
            if (last_we_edge >= 0) begin
                check_output("we_spacing", 64'(edge_count - last_we_edge), 64'(ELEM_CYCLES));
            end
            last_we_edge = edge_count;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_addrbA"}, 64'(addrbA), 64'(0));
        check_output({tag, "_addrbB"}, 64'(addrbB), 64'(0));
        check_output({tag, "_c_we"}, 64'(c_we), 64'(0));
        check_output({tag, "_c_addr"}, 64'(c_addr), 64'(0));
        check_output({tag, "_c_din"}, 64'(c_din), 64'(0));
        check_output({tag, "_busy"}, 64'(busy), 64'(0));
        check_output({tag, "_mm_done"}, 64'(mm_done), 64'(0));
`ifdef MATMUL_SAT_EN
        check_output({tag, "_ovf"}, 64'(ovf), 64'(0));
`endif
    endtask

    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
    endtask

    // Release reset at a falling edge with the given done flags; the next rising edge is edge 1.
    task automatic apply_stimulus(input logic a_done, input logic b_done);
        @(negedge clk);
        reset        = 1'b1;
        wrA_done     = a_done;
        wrB_done     = b_done;
        edge_count   = 0;
        we_count     = 0;
        last_we_edge = -1;
    endtask

    task automatic run_to_done(input string tag, input int expected_edge);
        while (!mm_done && edge_count < 400) step();
        check_output({tag, "_done_edge"}, 64'(edge_count), 64'(expected_edge));
        check_output({tag, "_we_count"}, 64'(we_count), 64'(N * M));
        check_output({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic activity;
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        wrA_done = 1'b0;
        wrB_done = 1'b0;
        for (int x = 0; x < (1 << AW); x++) begin
            mem_a[x] = '0;
            mem_b[x] = '0;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        $display("[TB] A all ones, B = 10..120");
        for (int x = 0; x < N*P; x++) mem_a[A_BASE + x] = 32'd1;
        for (int x = 0; x < P*M; x++) mem_b[B_BASE + x] = DW'(10 * (x + 1));
        push_expected();
        apply_stimulus(1'b1, 1'b1);
        step();
        check_output("t1_busy_first_fetch", 64'(busy), 64'(1));
        run_to_done("t1", DONE_EDGE);

        $display("[TB] A selects rows 0 and 3 of B");
        do_reset("t2_reset");
        for (int x = 0; x < N*P; x++) mem_a[A_BASE + x] = '0;
        mem_a[A_BASE + 0]         = 32'd1;
        mem_a[A_BASE + P + P - 1] = 32'd1;
        sb.delete();
        push_expected();
        apply_stimulus(1'b1, 1'b1);
        run_to_done("t2", DONE_EDGE);

        $display("[TB] wrB_done held low for 20 cycles");
        do_reset("t3_reset");
        push_expected();
        apply_stimulus(1'b1, 1'b0);
        activity = 1'b0;
        repeat (20) begin
            step();
            activity = activity | busy | c_we | mm_done;
        end
        check_output("t3_idle_activity", 64'(activity), 64'(0));
        @(negedge clk);
        wrB_done = 1'b1;
        step();
        check_output("t3_busy_after_start", 64'(busy), 64'(1));
        check_output("t3_addrbA_first", 64'(addrbA), 64'(A_BASE));
        check_output("t3_addrbB_first", 64'(addrbB), 64'(B_BASE));
        run_to_done("t3", 20 + DONE_EDGE);

        $display("[TB] reset during the third element");
        do_reset("t4_reset");
        sb.delete();
        push_expected();
        apply_stimulus(1'b1, 1'b1);
        repeat (2 * ELEM_CYCLES + 2) step();
        check_output("t4_busy_before_abort", 64'(busy), 64'(1));
        check_output("t4_we_before_abort", 64'(we_count), 64'(2));
        do_reset("t4_midop");
        sb.delete();
        push_expected();
        apply_stimulus(1'b1, 1'b1);
        run_to_done("t4", DONE_EDGE);

        $display("[TB] all words 0xFFFFFFFF");
        do_reset("t5_reset");
        for (int x = 0; x < N*P; x++) mem_a[A_BASE + x] = '1;
        for (int x = 0; x < P*M; x++) mem_b[B_BASE + x] = '1;
        sb.delete();
        push_expected();
        apply_stimulus(1'b1, 1'b1);
        run_to_done("t5", DONE_EDGE);
`ifdef MATMUL_SAT_EN
        check_output("t5_ovf", 64'(ovf), 64'(1));
`endif

        $display("[TB] done flags toggled after completion");
        activity = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            wrA_done = n[0];
            wrB_done = ~n[1];
            step();
            activity = activity | busy | c_we | ~mm_done;
        end
        check_output("t6_no_restart", 64'(activity), 64'(0));
        check_output("t6_mm_done_held", 64'(mm_done), 64'(1));
        do_reset("t6_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
